// File: rtl/onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_pulse_decoder
// Purpose  : Turns encoded priority tokens (3-bit index + "none" flag) back
//            into timed one-hot strobes. Tokens arrive on a valid/ready
//            handshake and are buffered in a 2-entry FIFO. Each token drives
//            one bit of y for PULSE_LEN cycles, followed by GAP_LEN forced
//            all-zero cycles.
// Params   : PULSE_LEN  cycles a pulse is held         (legal 1..15)
//            GAP_LEN    idle cycles after each pulse   (legal 0..15)
// Ports    : clk        clock, rising edge
//            rst_n      asynchronous active-low reset
//            in_valid   token present on in_idx / in_none
//            in_ready   token can be accepted this cycle (FIFO not full)
//            in_idx     encoded line index 0..7
//            in_none    token carries no request (accepted, discarded)
//            y          registered one-hot pulse output
//            busy       FSM active or FIFO non-empty
//            ovr_clr    clears overrun
//            overrun    sticky: in_valid seen while in_ready was low
// Config   : ONEHOT_DEC_OVERRUN_EN  defined -> sticky overrun flag present;
//            undefined -> overrun tied low, ovr_clr ignored.
// Revision : 1.0  initial release
// ============================================================================
module onehot_pulse_decoder #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_idx,
    input  logic       in_none,
    output logic [7:0] y,
    output logic       busy,
    input  logic       ovr_clr,
    output logic       overrun
);

    // Counter reload values; the counter counts down to zero, so a phase of
    // N cycles is loaded with N-1.
    localparam logic [3:0] c_PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0] c_GAP_LAST   = 4'(GAP_LEN - 1);
    localparam bit         c_HAS_GAP    = (GAP_LEN > 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // ------------------------------------------------------------------------
    // Token FIFO: 2 entries, 1-bit circular pointers that wrap naturally.
    // ------------------------------------------------------------------------
    logic [2:0] r_mem [0:1];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       r_in_ready;

    logic       w_push;
    logic       w_pop;
    logic       w_fifo_empty;
    logic [1:0] w_count_nxt;
    logic [2:0] w_head;
    logic [7:0] w_y_load;

    // "none" tokens complete the handshake but never occupy a slot.
    assign w_push       = in_valid & r_in_ready & ~in_none;
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_y_load     = 8'b1 << w_head;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // in_ready is registered from the post-edge occupancy, so a pop in the
    // current cycle only raises it one cycle later. It resets low and comes
    // up on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Pulse FSM: state register / next-state logic / output logic.
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_y;

    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] w_y_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_y     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_y_nxt     = w_y_load;
                    w_cnt_nxt   = c_PULSE_LAST;
                    w_state_nxt = c_ST_DRIVE;
                end
            end
            c_ST_DRIVE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (c_HAS_GAP) begin
                    w_y_nxt     = 8'h00;
                    w_cnt_nxt   = c_GAP_LAST;
                    w_state_nxt = c_ST_GAP;
                end else if (!w_fifo_empty) begin
                    // Zero-gap chaining: next one-hot value replaces the
                    // current one on the same edge.
                    w_pop     = 1'b1;
                    w_y_nxt   = w_y_load;
                    w_cnt_nxt = c_PULSE_LAST;
                end else begin
                    w_y_nxt     = 8'h00;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_GAP: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_y_nxt     = 8'h00;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_y_nxt     = 8'h00;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        y        = r_y;
        in_ready = r_in_ready;
        busy     = (r_state != c_ST_IDLE) | ~w_fifo_empty;
    end

    // ------------------------------------------------------------------------
    // Optional sticky overrun flag. Set has priority over clear.
    // ------------------------------------------------------------------------
`ifdef ONEHOT_DEC_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (in_valid && !r_in_ready) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_ovr_clr;

    assign w_unused_ovr_clr = ovr_clr;
    assign overrun          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_pulse_decoder
// Purpose  : Self-checking bench for onehot_pulse_decoder. Two instances:
//            u_dut_a with default timing (PULSE_LEN=4, GAP_LEN=1) and
//            u_dut_b with PULSE_LEN=2, GAP_LEN=0. Accepted tokens are pushed
//            to a per-instance expected queue; a monitor pops them as pulses
//            appear on y and also checks pulse lengths. Directed cycle checks
//            cover reset, latency, chaining, none tokens, overrun and reset
//            during a pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_onehot_pulse_decoder;

    localparam int PL_A = 4;
    localparam int GL_A = 1;
    localparam int PL_B = 2;
    localparam int GL_B = 0;

`ifdef ONEHOT_DEC_OVERRUN_EN
    localparam logic c_OVR_EN = 1'b1;
`else
    localparam logic c_OVR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic       valid_a, rdy_a, none_a, busy_a, clr_a, ovr_a;
    logic [2:0] idx_a;
    logic [7:0] y_a;
    logic       valid_b, rdy_b, none_b, busy_b, clr_b, ovr_b;
    logic [2:0] idx_b;
    logic [7:0] y_b;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a [$];
    int exp_b [$];

    onehot_pulse_decoder #(.PULSE_LEN(PL_A), .GAP_LEN(GL_A)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (valid_a),
        .in_ready (rdy_a),
        .in_idx   (idx_a),
        .in_none  (none_a),
        .y        (y_a),
        .busy     (busy_a),
        .ovr_clr  (clr_a),
        .overrun  (ovr_a)
    );

    onehot_pulse_decoder #(.PULSE_LEN(PL_B), .GAP_LEN(GL_B)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (valid_b),
        .in_ready (rdy_b),
        .in_idx   (idx_b),
        .in_none  (none_b),
        .y        (y_b),
        .busy     (busy_b),
        .ovr_clr  (clr_b),
        .overrun  (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present one token to instance A (sel_b=0) or B (sel_b=1) and hold it
    // until accepted; returns 1 time unit after the accepting edge.
    task automatic drive_tok(input logic sel_b, input logic [2:0] idx, input logic none);
        logic ok;
        logic rdy;
        ok = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        if (sel_b) begin
            valid_b = 1'b1; idx_b = idx; none_b = none;
        end else begin
            valid_a = 1'b1; idx_a = idx; none_a = none;
        end
        for (int i = 0; i < 50; i++) begin
            rdy = sel_b ? rdy_b : rdy_a;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check_eq("drive_ready", {31'd0, rdy}, 32'd1);
        end else begin
            if (!none) begin
                if (sel_b) exp_b.push_back(int'(idx));
                else       exp_a.push_back(int'(idx));
            end
            @(posedge clk);
            #1;
        end
        if (sel_b) valid_b = 1'b0;
        else       valid_a = 1'b0;
    endtask

    // Scoreboard monitor for instance A: every new nonzero y must match the
    // next queued token, start from zero (GAP_LEN>0) and last PL_A cycles.
    initial begin : mon_a
        logic [7:0] prev;
        int run;
        int e;
        prev = 8'h00;
        run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_a.delete();
                prev = 8'h00;
                run  = 0;
            end else begin
                if (y_a != prev) begin
                    if (prev != 8'h00) check_eq("a_pulse_len", run, PL_A);
                    if (y_a != 8'h00) begin
                        check_eq("a_gap_before_pulse", {24'd0, prev}, 32'd0);
                        if (exp_a.size() == 0) begin
                            check_eq("a_unexpected_pulse", {24'd0, y_a}, 32'd0);
                        end else begin
                            e = exp_a.pop_front();
                            check_eq("a_pulse_val", {24'd0, y_a}, 32'd1 << e);
                        end
                        run = 1;
                    end else begin
                        run = 0;
                    end
                end else if (y_a != 8'h00) begin
                    run++;
                end
                prev = y_a;
            end
        end
    end

    // Scoreboard monitor for instance B (zero gap: pulses may chain).
    initial begin : mon_b
        logic [7:0] prev;
        int run;
        int e;
        prev = 8'h00;
        run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_b.delete();
                prev = 8'h00;
                run  = 0;
            end else begin
                if (y_b != prev) begin
                    if (prev != 8'h00) check_eq("b_pulse_len", run, PL_B);
                    if (y_b != 8'h00) begin
                        if (exp_b.size() == 0) begin
                            check_eq("b_unexpected_pulse", {24'd0, y_b}, 32'd0);
                        end else begin
                            e = exp_b.pop_front();
                            check_eq("b_pulse_val", {24'd0, y_b}, 32'd1 << e);
                        end
                        run = 1;
                    end else begin
                        run = 0;
                    end
                end else if (y_b != 8'h00) begin
                    run++;
                end
                prev = y_b;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [7:0] seq_b [6];
        logic       drained;
        seq_b = '{8'h80, 8'h01, 8'h01, 8'h08, 8'h08, 8'h00};

        rst_n   = 1'b0;
        valid_a = 1'b1; idx_a = 3'd5; none_a = 1'b0; clr_a = 1'b0;
        valid_b = 1'b0; idx_b = 3'd0; none_b = 1'b0; clr_b = 1'b0;

        // Reset / idle with a valid token held at the input.
        repeat (3) @(negedge clk);
        check_eq("rst_y_a",     {24'd0, y_a},  32'h00);
        check_eq("rst_ready_a", {31'd0, rdy_a}, 32'd0);
        check_eq("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        check_eq("rst_ovr_a",   {31'd0, ovr_a}, 32'd0);
        check_eq("rst_y_b",     {24'd0, y_b},  32'h00);
        check_eq("rst_ready_b", {31'd0, rdy_b}, 32'd0);
        valid_a = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check_eq("rel_ready_a", {31'd0, rdy_a}, 32'd1);
        check_eq("rel_ready_b", {31'd0, rdy_b}, 32'd1);
        check_eq("rel_y_a",     {24'd0, y_a},  32'h00);

        // Single token idx=5 on the default instance: latency and length.
        drive_tok(1'b0, 3'd5, 1'b0);
        @(negedge clk);
        check_eq("single_y_e0",    {24'd0, y_a},   32'h00);
        check_eq("single_busy_e0", {31'd0, busy_a}, 32'd1);
        for (int k = 1; k <= PL_A; k++) begin
            @(negedge clk);
            check_eq("single_y_on", {24'd0, y_a}, 32'h20);
        end
        @(negedge clk);
        check_eq("single_y_off",   {24'd0, y_a},   32'h00);
        check_eq("single_busy_gap", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        check_eq("single_busy_end", {31'd0, busy_a}, 32'd0);

        // None token: accepted, no pulse, never busy.
        drive_tok(1'b0, 3'd6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("none_y",     {24'd0, y_a},   32'h00);
            check_eq("none_busy",  {31'd0, busy_a}, 32'd0);
            check_eq("none_ready", {31'd0, rdy_a},  32'd1);
        end

        // Zero-gap chaining on instance B: tokens 7,0,3.
        drive_tok(1'b1, 3'd7, 1'b0);
        drive_tok(1'b1, 3'd0, 1'b0);
        drive_tok(1'b1, 3'd3, 1'b0);
        @(negedge clk);
        check_eq("chain_ready_full", {31'd0, rdy_b}, 32'd0);
        check_eq("chain_y_0", {24'd0, y_b}, {24'd0, seq_b[0]});
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            check_eq("chain_y", {24'd0, y_b}, {24'd0, seq_b[k]});
        end

        // Overrun on instance A: fill FIFO then keep presenting tokens.
        drive_tok(1'b0, 3'd1, 1'b0);
        drive_tok(1'b0, 3'd2, 1'b0);
        drive_tok(1'b0, 3'd3, 1'b0);
        @(negedge clk);
        check_eq("ovr_ready_full", {31'd0, rdy_a}, 32'd0);
        valid_a = 1'b1; idx_a = 3'd4; none_a = 1'b0;
        @(negedge clk);
        check_eq("ovr_set", {31'd0, ovr_a}, {31'd0, c_OVR_EN});
        clr_a = 1'b1;
        @(negedge clk);
        check_eq("ovr_set_wins", {31'd0, ovr_a}, {31'd0, c_OVR_EN});
        valid_a = 1'b0;
        @(negedge clk);
        check_eq("ovr_cleared", {31'd0, ovr_a}, 32'd0);
        clr_a = 1'b0;

        // Let both instances drain so the scoreboards empty.
        drained = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) begin
                drained = 1'b1;
                break;
            end
        end
        check_eq("drain_idle", {31'd0, drained}, 32'd1);
        @(negedge clk);
        check_eq("drain_q_a", exp_a.size(), 32'd0);
        check_eq("drain_q_b", exp_b.size(), 32'd0);
        check_eq("ovr_b_off", {31'd0, ovr_b}, 32'd0);

        // Reset in the middle of a pulse with one token still queued.
        drive_tok(1'b0, 3'd2, 1'b0);
        drive_tok(1'b0, 3'd5, 1'b0);
        @(posedge clk);
        #2;
        check_eq("mid_y_before", {24'd0, y_a}, 32'h04);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_y",     {24'd0, y_a},   32'h00);
        check_eq("mid_rst_busy",  {31'd0, busy_a}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, rdy_a},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_ready", {31'd0, rdy_a}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_eq("mid_no_residual", {24'd0, y_a}, 32'h00);
        end
        check_eq("mid_busy_after", {31'd0, busy_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
